movegen_sequencer: RTL

- Controls one move-generation pass over the 64-cell square array.
- Sequence: flush stale move registers → run propagation for a fixed number of clocks → freeze the array → scan every square for arriving moves.
- Each hit is emitted as a (from, to, capture) record over a valid/ready stream.
- Sits between the search/engine FSM (start/done) and the square array (flush, run, square/direction select).

---
 rtl/movegen_sequencer_pkg.sv | 49 ++++
 rtl/dir_priority_enc.sv | 22 ++
 rtl/movegen_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/movegen_sequencer_pkg.sv
// Shared definitions for the move-generation sequencer and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package movegen_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_PROP  = 3'd2,
    ST_SEL   = 3'd3,
    ST_MASK  = 3'd4,
    ST_PICK  = 3'd5,
    ST_EMIT  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam int NUM_SQ          = 64;
  localparam int NUM_DIR         = 16;
  localparam int PROP_CYCLES_DEF = 9;   // 7 slide hops + knight hop + register latency

  // Direction indices: sliders first, then knights. Lower index = higher priority.
  localparam logic [3:0] DIR_U   = 4'd0;
  localparam logic [3:0] DIR_D   = 4'd1;
  localparam logic [3:0] DIR_L   = 4'd2;
  localparam logic [3:0] DIR_R   = 4'd3;
  localparam logic [3:0] DIR_UL  = 4'd4;
  localparam logic [3:0] DIR_UR  = 4'd5;
  localparam logic [3:0] DIR_DL  = 4'd6;
  localparam logic [3:0] DIR_DR  = 4'd7;
  localparam logic [3:0] DIR_UUL = 4'd8;
  localparam logic [3:0] DIR_UUR = 4'd9;
  localparam logic [3:0] DIR_LLU = 4'd10;
  localparam logic [3:0] DIR_RRU = 4'd11;
  localparam logic [3:0] DIR_DDL = 4'd12;
  localparam logic [3:0] DIR_DDR = 4'd13;
  localparam logic [3:0] DIR_LLD = 4'd14;
  localparam logic [3:0] DIR_RRD = 4'd15;

  // Move-word field positions inside a cell move register
  localparam int MW_COLOR_HI  = 10;
  localparam int MW_MANHATTAN = 9;
  localparam int MW_DIAGONAL  = 8;
  localparam int MW_COLOR_LO  = 7;
  localparam int MW_PAWN      = 6;
  localparam int MW_SRC_MSB   = 5;
  localparam int MW_SRC_LSB   = 0;

endpackage

// File: rtl/dir_priority_enc.sv
// Lowest-set-bit priority encoder over the per-square direction hit mask.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask (direction hits, bit 0 = highest priority), idx (winning direction), any (mask nonzero).
module dir_priority_enc
  import movegen_sequencer_pkg::*;
(
  input  logic [NUM_DIR-1:0] mask,
  output logic [3:0]         idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    any = |mask;
    // Walk from the top so the lowest set bit is the last assignment to win.
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/movegen_sequencer.sv
// Sequences one move-generation pass: flush, propagate, freeze, scan all squares, stream hits.
// Latency: 1 + PROP_CYCLES + 3 clks/square + 2 clks/hit (ready high) from start to done.
// Backpressure: mv_* held stable while mv_valid & !mv_ready; the scan stalls in EMIT.
// Ports: start/abort/engine_color/busy/done to the engine; array_flush/array_run/sq_sel/dir_sel/
//        color_out and sq_hit/sq_occupied/dir_src with the square array; mv_* stream to consumer;
//        move_count/overflow pass statistics.
module movegen_sequencer
  import movegen_sequencer_pkg::*;
#(
  parameter int PROP_CYCLES = PROP_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          engine_color,
  output logic                          color_out,
  output logic                          busy,
  output logic                          done,
  output logic                          array_flush,
  output logic                          array_run,
  output logic [5:0]                    sq_sel,
  input  logic [NUM_DIR-1:0]            sq_hit,
  input  logic                          sq_occupied,
  output logic [3:0]                    dir_sel,
  input  logic [MW_SRC_MSB:MW_SRC_LSB]  dir_src,
  output logic                          mv_valid,
  input  logic                          mv_ready,
  output logic [5:0]                    mv_from,
  output logic [5:0]                    mv_to,
  output logic                          mv_capture,
  output logic [7:0]                    move_count,
  output logic                          overflow
);

  localparam int CW = ($clog2(PROP_CYCLES) > 0) ? $clog2(PROP_CYCLES) : 1;

  state_t             state;
  logic [CW-1:0]      prop_cnt;
  logic [NUM_DIR-1:0] mask_reg;
  logic               cap_reg;
  logic [NUM_DIR-1:0] mask_cleared;
  logic [NUM_DIR-1:0] enc_in;
  logic [3:0]         enc_idx;
  logic               enc_any;

  assign mask_cleared = mask_reg & ~(NUM_DIR'(1) << dir_sel);

  // dir_sel is kept pointing at the next pending direction one cycle ahead of
  // EMIT (updated when the mask is captured and when a record is accepted), so
  // dir_src is already settled during PICK and can be registered into mv_from
  // on the PICK->EMIT edge without an extra cycle per hit.
  always_comb begin
    enc_in = mask_reg;
    case (state)
      ST_MASK: enc_in = sq_hit;
      ST_EMIT: enc_in = mask_cleared;
      default: enc_in = mask_reg;
    endcase
  end

  dir_priority_enc u_enc (
    .mask (enc_in),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      prop_cnt    <= '0;
      mask_reg    <= '0;
      cap_reg     <= 1'b0;
      color_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_flush <= 1'b0;
      array_run   <= 1'b0;
      sq_sel      <= '0;
      dir_sel     <= '0;
      mv_valid    <= 1'b0;
      mv_from     <= '0;
      mv_to       <= '0;
      mv_capture  <= 1'b0;
      move_count  <= '0;
      overflow    <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      // Drop every strobe on the same edge; counters keep their value.
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_flush <= 1'b0;
      array_run   <= 1'b0;
      mv_valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            color_out   <= engine_color;
            move_count  <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            array_flush <= 1'b1;
            array_run   <= 1'b1;
            state       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          array_flush <= 1'b0;
          prop_cnt    <= CW'(PROP_CYCLES - 1);
          state       <= ST_PROP;
        end
        ST_PROP: begin
          if (prop_cnt == '0) begin
            array_run <= 1'b0;
            sq_sel    <= '0;
            state     <= ST_SEL;
          end else begin
            prop_cnt <= prop_cnt - 1'b1;
          end
        end
        ST_SEL: state <= ST_MASK;
        ST_MASK: begin
          mask_reg <= sq_hit;
          cap_reg  <= sq_occupied;
          dir_sel  <= enc_idx;
          state    <= ST_PICK;
        end
        ST_PICK: begin
          if (enc_any) begin
            mv_from    <= dir_src;
            mv_to      <= sq_sel;
            mv_capture <= cap_reg;
            mv_valid   <= 1'b1;
            state      <= ST_EMIT;
          end else if (sq_sel == 6'(NUM_SQ - 1)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            sq_sel <= sq_sel + 1'b1;
            state  <= ST_SEL;
          end
        end
        ST_EMIT: begin
          if (mv_ready) begin
            mv_valid <= 1'b0;
            mask_reg <= mask_cleared;
            dir_sel  <= enc_idx;
            if (move_count == 8'hFF) overflow <= 1'b1;
            else                     move_count <= move_count + 1'b1;
            state    <= ST_PICK;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
